mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single memory port between the instruction-fetch path and the data-access path of the multicycle MIPS datapath. Each requester presents a held request. The block round-robin arbitrates between them and drives the memory MOV/RW/address/data/size signals. It completes the MOC handshake, returns read data, and reports misaligned or timed-out accesses. It sits between the control unit/datapath (IR load and MDR/MAR paths) and the memory model.

## Interface
- TIMEOUT_CYCLES, 15: ACCESS edges without MOC before an access is aborted with error; legal range 1..255.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- f_req  in  1  fetch request; held until f_done.
- f_addr  in  32  fetch address; word access only.
- f_done  out  1  one-cycle completion pulse for fetch.
- f_rdata  out  32  fetched word; valid with f_done, held until the next fetch completion.
- f_err  out  1  error pulse, coincident with f_done.
- d_req  in  1  data request; held until d_done.
- d_rw  in  1  1 = read, 0 = write.
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_done  out  1  one-cycle completion pulse for data.
- d_rdata  out  32  read data; valid with d_done on reads, unchanged on writes.
- d_err  out  1  error pulse, coincident with d_done.
- MOV  out  1  memory operation valid.
- RW  out  1  1 = read, 0 = write.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_size  out  2  access size; same encoding as d_size.
- MOC  in  1  memory operation complete; level, held high until MOV drops.
- mem_rdata  in  32  memory read data; valid while MOC = 1.
- busy  out  1  1 whenever state != IDLE.
- owner  out  1  0 = fetch, 1 = data; current or last grant.

## Operation
- States:
  - IDLE: arbitrate among requesters.
  - ACCESS: MOV high, wait for MOC or timeout.
  - REJECT: one cycle, used for illegal requests.
  - RELEASE: MOV low, wait for MOC = 0.
- **Arbitration in IDLE:**
  - A single requester is granted directly.
  - If both request, the one that is not `owner` is granted (round-robin).
  - `owner` updates on every grant.
- **Legality check at grant.** A request is illegal if any of the following holds:
  - d_size = 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 00.
- Fetch requests always use size 10, RW = 1, mem_wdata = 0.
- **Legal grant:** mem_addr, RW, mem_size and mem_wdata are registered from the granted requester. MOV is set to 1. Next state is ACCESS. The timeout counter is cleared.
- **Illegal grant:** MOV stays 0. Next state is REJECT. In the following cycle x_done = x_err = 1 and x_rdata is unchanged; the state then returns to IDLE.
- **ACCESS, MOC = 1 at an edge:**
  - On a read, mem_rdata is captured into x_rdata.
  - x_done pulses with x_err = 0.
  - MOV goes to 0 and the state moves to RELEASE.
- **ACCESS, MOC = 0 at an edge:** the counter increments. When it reaches TIMEOUT_CYCLES, x_done = x_err = 1, MOV goes to 0, the state returns to IDLE and x_rdata is unchanged.
- **RELEASE:** the state returns to IDLE at the first edge with MOC = 0. No new MOV is issued while MOC is high.
- mem_addr, mem_wdata, RW and mem_size hold their values after MOV drops, until the next grant.
- A requester that drops x_req mid-access does not abort the access; x_done still pulses.
- Reset mid-operation abandons the access with no done or err pulse.

## Timing
- **Reset values:**
  - All outputs are 0: MOV, RW, mem_addr, mem_wdata, mem_size, done/err pulses, rdata, busy.
  - owner = 1, so that fetch wins the first contention.
  - State is IDLE and the counter is 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- **Legal access timeline:**
  - Request sampled at IDLE edge N.
  - MOV high after edge N.
  - MOC sampled high at edge N+k (k ≥ 1).
  - x_done high for the cycle after edge N+k.
  - Minimum request-to-done latency is 2 edges.
- **Timeout:** x_err and x_done are high after edge N + TIMEOUT_CYCLES.
- **Reject:** x_done and x_err are high after edge N+1.
- **Back-to-back:** earliest next MOV is after the edge following MOC low in RELEASE. A requester may keep x_req high through x_done to request again.
- **Simultaneous requests:** a request arriving during a grant to the other port waits for IDLE and then wins by round-robin.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, REJECT, RELEASE);
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - owner constants OWN_FETCH, OWN_DATA.
- Sub-module mem_arb_timeout: 8-bit counter with clear/enable inputs and an expired output at TIMEOUT_CYCLES. Everything else stays in one module.

## Test plan
- **Fetch read.** f_addr = 0x00000100; memory raises MOC 3 edges after MOV with rdata 0xDEADBEEF.
  - MOV high 3 cycles, RW = 1, mem_size = 10.
  - f_done pulses once with f_rdata = 0xDEADBEEF; MOV low in the f_done cycle.
- **Contention.** f_req and d_req both high, held, right after reset.
  - Fetch is granted first, then data, then fetch.
  - owner toggles on each grant; there are never two MOV assertions without an intervening RELEASE→IDLE.
- **Legal half write.** d_rw = 0, d_size = 01, d_addr = 0x00001002, d_wdata = 0x0000ABCD.
  - Expect RW = 0, mem_size = 01, mem_wdata = 0x0000ABCD, d_done, d_rdata unchanged.
- **Misaligned half.** d_addr = 0x00001003, d_size = 01.
  - d_done and d_err high 2 cycles after the request; MOV never asserted.
- **Timeout.** TIMEOUT_CYCLES = 15, MOC tied to 0.
  - d_err and d_done after edge N+15, MOV low after that edge.
  - A following fetch request is still serviced normally.
- **Reset and RELEASE.**
  - Assert reset during ACCESS: MOV, busy and the pulses go to 0 immediately with no clock.
  - Separately, hold MOC high 4 cycles after done: no new MOV until the edge after MOC falls.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    REJECT  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Access size encoding shared by d_size and mem_size (2'b11 is reserved)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Owner encoding for the owner output
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // An access is legal when its size is defined and the address is naturally aligned.
  function automatic logic access_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    access_legal = ok;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Timeout counter for one memory access: cleared at grant, advanced on each
// ACCESS edge without MOC. expired flags the edge on which the count reaches
// TIMEOUT_CYCLES, so the abort is registered on that same edge.
module mem_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q;

  // Count waiting edges; clear has priority so a fresh grant always starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = en && (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// data access. Checks alignment at grant, drives MOV/RW/address/data/size,
// completes the MOC handshake and reports rejected or timed-out accesses.
//
// Handshake: a requester raises x_req with its command and holds both stable
// until x_done pulses for one cycle (x_err qualifies it). Holding x_req high
// through x_done issues another request. Towards memory, MOV is held until MOC
// is seen high (or the timeout fires); MOC must then stay high until MOV drops,
// and no new MOV is issued until MOC has been seen low again.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        MOV,
  output logic        RW,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        MOC,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner,
  output arb_state_e  dbg_state
);

  arb_state_e  state_q, state_n;
  logic        mov_q, mov_n;
  logic        rw_q, rw_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic [1:0]  size_q, size_n;
  logic        owner_q, owner_n;
  logic        f_done_q, f_done_n, f_err_q, f_err_n;
  logic        d_done_q, d_done_n, d_err_q, d_err_n;
  logic [31:0] f_rdata_q, f_rdata_n;
  logic [31:0] d_rdata_q, d_rdata_n;
  logic        grant_data, grant_legal;
  logic        tmo_clr, tmo_en, tmo_expired;

  assign tmo_en = (state_q == ACCESS) && !MOC;

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Register FSM state and every output; owner resets to data so fetch wins first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mov_q     <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      owner_q   <= OWN_DATA;
      f_done_q  <= 1'b0;
      f_err_q   <= 1'b0;
      f_rdata_q <= '0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_n;
      mov_q     <= mov_n;
      rw_q      <= rw_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      size_q    <= size_n;
      owner_q   <= owner_n;
      f_done_q  <= f_done_n;
      f_err_q   <= f_err_n;
      f_rdata_q <= f_rdata_n;
      d_done_q  <= d_done_n;
      d_err_q   <= d_err_n;
      d_rdata_q <= d_rdata_n;
    end
  end

  // Next-state and next-output logic: arbitration, legality, MOC handshake and timeout.
  always_comb begin
    state_n     = state_q;
    mov_n       = mov_q;
    rw_n        = rw_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    size_n      = size_q;
    owner_n     = owner_q;
    f_done_n    = 1'b0;
    f_err_n     = 1'b0;
    f_rdata_n   = f_rdata_q;
    d_done_n    = 1'b0;
    d_err_n     = 1'b0;
    d_rdata_n   = d_rdata_q;
    grant_data  = 1'b0;
    grant_legal = 1'b0;
    tmo_clr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          // Under contention the port that did not own the last grant wins.
          grant_data  = d_req && (!f_req || (owner_q == OWN_FETCH));
          grant_legal = grant_data ? access_legal(d_size, d_addr[1:0])
                                   : access_legal(SZ_WORD, f_addr[1:0]);
          owner_n     = grant_data ? OWN_DATA : OWN_FETCH;
          if (grant_legal) begin
            state_n = ACCESS;
            mov_n   = 1'b1;
            tmo_clr = 1'b1;
            if (grant_data) begin
              rw_n    = d_rw;
              addr_n  = d_addr;
              wdata_n = d_wdata;
              size_n  = d_size;
            end else begin
              rw_n    = 1'b1;
              addr_n  = f_addr;
              wdata_n = '0;
              size_n  = SZ_WORD;
            end
          end else begin
            state_n = REJECT;
          end
        end
      end

      ACCESS: begin
        if (MOC) begin
          mov_n   = 1'b0;
          state_n = RELEASE;
          if (owner_q == OWN_DATA) begin
            d_done_n = 1'b1;
            if (rw_q) d_rdata_n = mem_rdata;
          end else begin
            f_done_n  = 1'b1;
            f_rdata_n = mem_rdata;
          end
        end else if (tmo_expired) begin
          mov_n   = 1'b0;
          state_n = IDLE;
          if (owner_q == OWN_DATA) begin
            d_done_n = 1'b1;
            d_err_n  = 1'b1;
          end else begin
            f_done_n = 1'b1;
            f_err_n  = 1'b1;
          end
        end
      end

      REJECT: begin
        state_n = IDLE;
        if (owner_q == OWN_DATA) begin
          d_done_n = 1'b1;
          d_err_n  = 1'b1;
        end else begin
          f_done_n = 1'b1;
          f_err_n  = 1'b1;
        end
      end

      RELEASE: begin
        // Memory must see MOV low and drop MOC before the port is reused.
        if (!MOC) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign MOV       = mov_q;
  assign RW        = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;
  assign owner     = owner_q;
  assign f_done    = f_done_q;
  assign f_err     = f_err_q;
  assign f_rdata   = f_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized
// single-transaction traffic against a behavioural memory and result model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_rw;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        f_done, f_err, d_done, d_err;
  logic [31:0] f_rdata, d_rdata;
  logic        MOV, RW, MOC;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        busy, owner;
  arb_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // memory model controls and observations
  int          mem_latency = 1;
  int          mem_hold    = 0;
  bit          mem_dead    = 0;
  logic [31:0] mem_data    = '0;
  int          wait_cnt, hold_cnt;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_rw;
  logic [1:0]  seen_size;

  // bus monitor observations
  logic mov_prev;
  bit   saw_idle;
  int   mov_viol, mov_rise_cnt, mov_hi_cnt, f_done_cnt, d_done_cnt;
  logic rise_owner_q[$];

  // result model
  logic [31:0] exp_f_rdata, exp_d_rdata;
  logic [31:0] exp_q[$];
  logic        mov_at_done;

  mem_port_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .MOV(MOV), .RW(RW), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .MOC(MOC), .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // memory: answers MOC mem_latency edges after MOV, holds MOC mem_hold extra cycles
  always @(negedge clk) begin
    if (reset) begin
      MOC = 1'b0; wait_cnt = 0; hold_cnt = 0;
    end else if (!MOV) begin
      wait_cnt = 0;
      if (MOC) begin
        if (hold_cnt > 0) hold_cnt--;
        else MOC = 1'b0;
      end
    end else if (!MOC && !mem_dead) begin
      wait_cnt++;
      if (wait_cnt >= mem_latency) begin
        MOC = 1'b1; mem_rdata = mem_data; hold_cnt = mem_hold;
        seen_addr = mem_addr; seen_rw = RW; seen_size = mem_size; seen_wdata = mem_wdata;
      end
    end
  end

  // bus monitor: MOV rises, owner at each grant, pulse counts
  always @(negedge clk) begin
    if (reset) begin
      mov_prev = 1'b0; saw_idle = 1'b1;
    end else begin
      if (MOV && !mov_prev) begin
        if (!saw_idle) mov_viol++;
        saw_idle = 1'b0;
        rise_owner_q.push_back(owner);
        mov_rise_cnt++;
      end
      if (!busy) saw_idle = 1'b1;
      if (MOV) mov_hi_cnt++;
      if (f_done) f_done_cnt++;
      if (d_done) d_done_cnt++;
      mov_prev = MOV;
    end
  end

  function automatic logic model_legal(input bit port, input logic [1:0] size, input logic [31:0] addr);
    if (!port) return (addr % 4) == 0;
    if (size == 2'd3) return 1'b0;
    if (size == 2'd1) return (addr % 2) == 0;
    if (size == 2'd2) return (addr % 4) == 0;
    return 1'b1;
  endfunction

  // driver: one request on port (0 fetch, 1 data), waits for done, then drops req
  task automatic run_req(input bit port, input logic rw, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic err, output logic [31:0] rdata,
                         output bit got);
    int c0;
    @(negedge clk);
    if (port) begin
      d_req = 1'b1; d_rw = rw; d_size = size; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    c0 = cycle; got = 0; lat = 0; err = 1'b0; rdata = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      if (port ? d_done : f_done) begin
        got = 1; lat = cycle - c0;
        err = port ? d_err : f_err;
        rdata = port ? d_rdata : f_rdata;
        mov_at_done = MOV;
      end
    end
    @(negedge clk);
    if (port) d_req = 1'b0; else f_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy && !MOC) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_idle arbiter still busy"); end
  endtask

  task automatic test_reset();
    checks += 6;
    if (MOV !== 1'b0) begin errors++; $display("FAIL reset_mov got %b exp 0", MOV); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner got %b exp 1", owner); end
    if ({RW, mem_size, mem_addr, mem_wdata} !== 67'd0) begin
      errors++; $display("FAIL reset_bus got %h exp 0", {RW, mem_size, mem_addr, mem_wdata}); end
    if ({f_done, f_err, d_done, d_err, f_rdata, d_rdata} !== 68'd0) begin
      errors++; $display("FAIL reset_results got %h exp 0", {f_done, f_err, d_done, d_err, f_rdata, d_rdata}); end
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_contention();
    logic got_q[$];
    logic last = 1'b1;
    logic g;
    logic [31:0] exp_owner_q[$];
    mem_latency = 2; mem_data = 32'hC0FFEE01;
    rise_owner_q.delete(); mov_viol = 0;
    for (int i = 0; i < 3; i++) begin
      g = ~last; exp_owner_q.push_back({31'd0, g}); last = g;
    end
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h0000_0040;
    d_req = 1'b1; d_rw = 1'b1; d_size = SZ_WORD; d_addr = 32'h0000_0200; d_wdata = '0;
    for (int i = 0; i < 100 && got_q.size() < 3; i++) begin
      @(posedge clk); #1;
      if (f_done) got_q.push_back(1'b0);
      if (d_done) got_q.push_back(1'b1);
    end
    @(negedge clk);
    f_req = 1'b0; d_req = 1'b0;
    wait_idle();
    exp_f_rdata = mem_data; exp_d_rdata = mem_data;
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL contention_count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_owner_q[i][0]) begin
        errors++; $display("FAIL contention_order[%0d] got %b exp %b", i, got_q[i], exp_owner_q[i][0]); end
      checks++;
      if (i < rise_owner_q.size() && rise_owner_q[i] !== exp_owner_q[i][0]) begin
        errors++; $display("FAIL contention_owner[%0d] got %b exp %b", i, rise_owner_q[i], exp_owner_q[i][0]); end
    end
    checks++;
    if (mov_viol != 0) begin errors++; $display("FAIL contention_release got %0d exp 0", mov_viol); end
  endtask

  task automatic test_fetch_read();
    int lat; logic err; logic [31:0] rd; bit got;
    mem_latency = 3; mem_data = 32'hDEADBEEF;
    mov_hi_cnt = 0; f_done_cnt = 0;
    run_req(1'b0, 1'b1, SZ_WORD, 32'h0000_0100, '0, lat, err, rd, got);
    wait_idle();
    exp_f_rdata = 32'hDEADBEEF;
    checks += 8;
    if (!got || lat != 4) begin errors++; $display("FAIL fetch_latency got %0d exp 4", lat); end
    if (err !== 1'b0) begin errors++; $display("FAIL fetch_err got %b exp 0", err); end
    if (rd !== exp_f_rdata) begin errors++; $display("FAIL fetch_rdata got %h exp %h", rd, exp_f_rdata); end
    if (mov_hi_cnt != 3) begin errors++; $display("FAIL fetch_mov_cycles got %0d exp 3", mov_hi_cnt); end
    if (mov_at_done !== 1'b0) begin errors++; $display("FAIL fetch_mov_at_done got %b exp 0", mov_at_done); end
    if (f_done_cnt != 1) begin errors++; $display("FAIL fetch_done_pulses got %0d exp 1", f_done_cnt); end
    if ({seen_rw, seen_size} !== 3'b110) begin errors++; $display("FAIL fetch_rw_size got %b exp 110", {seen_rw, seen_size}); end
    if ({seen_addr, seen_wdata} !== {32'h100, 32'h0}) begin
      errors++; $display("FAIL fetch_addr_wdata got %h exp %h", {seen_addr, seen_wdata}, {32'h100, 32'h0}); end
  endtask

  task automatic test_half_write();
    int lat; logic err; logic [31:0] rd; bit got;
    mem_latency = 1; mem_data = 32'h5555AAAA;
    run_req(1'b1, 1'b0, SZ_HALF, 32'h0000_1002, 32'h0000_ABCD, lat, err, rd, got);
    wait_idle();
    checks += 5;
    if (!got || lat != 2) begin errors++; $display("FAIL half_latency got %0d exp 2", lat); end
    if (err !== 1'b0) begin errors++; $display("FAIL half_err got %b exp 0", err); end
    if (rd !== exp_d_rdata) begin errors++; $display("FAIL half_rdata got %h exp %h", rd, exp_d_rdata); end
    if ({seen_rw, seen_size} !== 3'b001) begin errors++; $display("FAIL half_rw_size got %b exp 001", {seen_rw, seen_size}); end
    if ({seen_addr, seen_wdata} !== {32'h1002, 32'hABCD}) begin
      errors++; $display("FAIL half_addr_wdata got %h exp %h", {seen_addr, seen_wdata}, {32'h1002, 32'hABCD}); end
  endtask

  task automatic test_misaligned();
    int lat; logic err; logic [31:0] rd; bit got; int rises;
    rises = mov_rise_cnt;
    run_req(1'b1, 1'b1, SZ_HALF, 32'h0000_1003, '0, lat, err, rd, got);
    wait_idle();
    checks += 4;
    if (!got || lat != 2) begin errors++; $display("FAIL misaligned_latency got %0d exp 2", lat); end
    if (err !== 1'b1) begin errors++; $display("FAIL misaligned_err got %b exp 1", err); end
    if (rd !== exp_d_rdata) begin errors++; $display("FAIL misaligned_rdata got %h exp %h", rd, exp_d_rdata); end
    if (mov_rise_cnt != rises) begin errors++; $display("FAIL misaligned_mov got %0d exp %0d", mov_rise_cnt, rises); end
  endtask

  task automatic test_timeout();
    int lat; logic err; logic [31:0] rd; bit got;
    mem_dead = 1;
    run_req(1'b1, 1'b1, SZ_WORD, 32'h0000_0300, '0, lat, err, rd, got);
    checks += 4;
    if (!got || lat != 16) begin errors++; $display("FAIL timeout_latency got %0d exp 16", lat); end
    if (err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", err); end
    if (mov_at_done !== 1'b0) begin errors++; $display("FAIL timeout_mov got %b exp 0", mov_at_done); end
    if (rd !== exp_d_rdata) begin errors++; $display("FAIL timeout_rdata got %h exp %h", rd, exp_d_rdata); end
    mem_dead = 0; mem_latency = 2; mem_data = 32'h12345678;
    wait_idle();
    run_req(1'b0, 1'b1, SZ_WORD, 32'h0000_0104, '0, lat, err, rd, got);
    wait_idle();
    exp_f_rdata = 32'h12345678;
    checks += 2;
    if (!got || lat != 3 || err !== 1'b0) begin
      errors++; $display("FAIL after_timeout_fetch got lat %0d err %b exp lat 3 err 0", lat, err); end
    if (rd !== exp_f_rdata) begin errors++; $display("FAIL after_timeout_rdata got %h exp %h", rd, exp_f_rdata); end
  endtask

  task automatic test_release_hold();
    bit got = 0; bit low = 0; int viol = 0;
    mem_latency = 1; mem_hold = 4; mem_data = 32'h0BADF00D;
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h0000_0108;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (f_done) got = 1;
    end
    mem_hold = 0;
    for (int i = 0; i < 20 && !low; i++) begin
      if (!MOC) low = 1;
      else begin
        if (MOV) viol++;
        @(posedge clk); #1;
      end
    end
    checks += 3;
    if (!got || !low) begin errors++; $display("FAIL hold_handshake got done %b moc_low %b exp 1 1", got, low); end
    if (viol != 0) begin errors++; $display("FAIL hold_mov_during_moc got %0d exp 0", viol); end
    if (MOV !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_first_low_edge got mov %b busy %b exp 0 0", MOV, busy); end
    @(posedge clk); #1;
    checks++;
    if (MOV !== 1'b1) begin errors++; $display("FAIL hold_next_mov got %b exp 1", MOV); end
    @(negedge clk);
    f_req = 1'b0;
    wait_idle();
    exp_f_rdata = mem_data;
    checks++;
    if (f_rdata !== exp_f_rdata) begin errors++; $display("FAIL hold_rdata got %h exp %h", f_rdata, exp_f_rdata); end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic err; logic [31:0] rd, addr, wdata, exp_rd; bit got, port;
    logic rw, legal; logic [1:0] size; int rises;
    for (int n = 0; n < 30; n++) begin
      port = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      wdata = $urandom;
      mem_latency = $urandom_range(1, 4);
      mem_hold = $urandom_range(0, 2);
      mem_data = $urandom;
      legal = model_legal(port, size, addr);
      exp_lat = legal ? mem_latency + 1 : 2;
      if (legal && (!port || rw)) begin
        if (port) exp_d_rdata = mem_data; else exp_f_rdata = mem_data;
      end
      exp_q.push_back(port ? exp_d_rdata : exp_f_rdata);
      rises = mov_rise_cnt;
      run_req(port, rw, size, addr, wdata, lat, err, rd, got);
      wait_idle();
      exp_rd = exp_q.pop_front();
      checks += 4;
      if (!got || lat != exp_lat) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", n, lat, exp_lat); end
      if (err !== ~legal) begin errors++; $display("FAIL rand_err[%0d] got %b exp %b", n, err, ~legal); end
      if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d] got %h exp %h", n, rd, exp_rd); end
      if (mov_rise_cnt != rises + (legal ? 1 : 0)) begin
        errors++; $display("FAIL rand_mov[%0d] got %0d exp %0d", n, mov_rise_cnt - rises, legal ? 1 : 0); end
      if (legal) begin
        checks++;
        if ({seen_addr, seen_rw, seen_size, seen_wdata} !==
            {addr, (port ? rw : 1'b1), (port ? size : SZ_WORD), (port ? wdata : 32'd0)}) begin
          errors++; $display("FAIL rand_bus[%0d] got %h exp %h", n, {seen_addr, seen_rw, seen_size, seen_wdata},
                             {addr, (port ? rw : 1'b1), (port ? size : SZ_WORD), (port ? wdata : 32'd0)}); end
      end
    end
    mem_hold = 0;
  endtask

  task automatic test_reset_mid_access();
    bit up = 0;
    mem_dead = 1;
    @(negedge clk);
    d_req = 1'b1; d_rw = 1'b1; d_size = SZ_WORD; d_addr = 32'h0000_0400;
    for (int i = 0; i < 10 && !up; i++) begin
      @(posedge clk); #1;
      if (MOV) up = 1;
    end
    #2 reset = 1'b1;
    #1;
    exp_f_rdata = '0; exp_d_rdata = '0;
    checks += 4;
    if (!up) begin errors++; $display("FAIL reset_mid_no_mov got 0 exp 1"); end
    if (MOV !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_bus got mov %b busy %b exp 0 0", MOV, busy); end
    if ({d_done, d_err, owner} !== 3'b001) begin
      errors++; $display("FAIL reset_mid_pulses got %b exp 001", {d_done, d_err, owner}); end
    if (d_rdata !== exp_d_rdata) begin errors++; $display("FAIL reset_mid_rdata got %h exp %h", d_rdata, exp_d_rdata); end
    @(negedge clk);
    d_req = 1'b0; mem_dead = 0;
    @(negedge clk);
    reset = 1'b0;
    d_done_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (d_done_cnt != 0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_mid_after got done %0d state %0d exp 0 0", d_done_cnt, dbg_state); end
  endtask

  initial begin
    reset = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_rw = 1'b0; d_size = '0; d_addr = '0; d_wdata = '0;
    MOC = 1'b0; mem_rdata = '0;
    mov_viol = 0; mov_rise_cnt = 0; mov_hi_cnt = 0; f_done_cnt = 0; d_done_cnt = 0;
    exp_f_rdata = '0; exp_d_rdata = '0; mov_at_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_contention();
    test_fetch_read();
    test_half_write();
    test_misaligned();
    test_timeout();
    test_release_hold();
    test_random();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
